// File: rtl/pedido_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pedido_scheduler
// Description : Round-robin order scheduler for a coffee machine. Queues one
//               order per panel, serves them one at a time, watches the
//               machine until extraction, and falls into a fault state if the
//               machine does not reach extraction within TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pedido_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [3:0]          machine_state,
    input  logic                clear_fault,
    output logic                start,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     pending,
    output logic                busy,
    output logic                fault,
    output logic [7:0]          served_count,
    output logic [2:0]          sched_state
);

    localparam int              c_IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              c_CW       = $clog2(TIMEOUT + 1);
    localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(NREQ - 1);
    localparam logic [c_CW-1:0] c_CNT_LIM  = c_CW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] c_ONE      = NREQ'(1);
    localparam logic [3:0]      c_MS_IDLE  = 4'd0;
    localparam logic [3:0]      c_MS_EXTR  = 4'd8;

    typedef enum logic [2:0] {
        SCH_IDLE  = 3'd0,
        SCH_START = 3'd1,
        SCH_BREW  = 3'd2,
        SCH_DONE  = 3'd3,
        SCH_FAULT = 3'd4
    } sch_state_t;

    sch_state_t         r_state;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_pending;
    logic [c_IW-1:0]    r_gnt_idx;
    logic [c_IW-1:0]    r_last;
    logic [c_CW-1:0]    r_cnt;
    logic [7:0]         r_served;

    logic               w_active;
    logic               w_timeout;
    logic [NREQ-1:0]    w_pend_clr;
    logic               w_win_found;
    logic [c_IW-1:0]    w_win_idx;
    logic [c_IW-1:0]    w_probe;

    // The order watchdog expires on the cycle whose increment would reach TIMEOUT.
    assign w_active   = (r_state == SCH_START) || (r_state == SCH_BREW);
    assign w_timeout  = w_active && (r_cnt == c_CNT_LIM);
    assign w_pend_clr = ((r_state == SCH_DONE) || w_timeout) ? r_grant : '0;

    // Round-robin search: first pending panel after the last one served.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_probe     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_probe = c_IW'((int'(r_last) + k) % NREQ);
            if (!w_win_found && r_pending[w_probe]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_probe;
            end
        end
    end

    // Pending queue: new requests win over a same-cycle clear of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | req;
        end
    end

    // Scheduler FSM with grant, watchdog, pointer and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SCH_IDLE;
            r_grant   <= '0;
            r_gnt_idx <= '0;
            r_last    <= c_LAST_RST;
            r_cnt     <= '0;
            r_served  <= '0;
        end else begin
            case (r_state)
                SCH_IDLE: begin
                    if (w_win_found) begin
                        r_grant   <= c_ONE << w_win_idx;
                        r_gnt_idx <= w_win_idx;
                        r_cnt     <= '0;
                        r_state   <= SCH_START;
                    end
                end
                SCH_START: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) begin
                        r_grant <= '0;
                        r_last  <= r_gnt_idx;
                        r_state <= SCH_FAULT;
                    end else if (machine_state != c_MS_IDLE) begin
                        r_state <= SCH_BREW;
                    end
                end
                SCH_BREW: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) begin
                        r_grant <= '0;
                        r_last  <= r_gnt_idx;
                        r_state <= SCH_FAULT;
                    end else if (machine_state == c_MS_EXTR) begin
                        r_state <= SCH_DONE;
                    end
                end
                SCH_DONE: begin
                    r_served <= r_served + 8'd1;
                    r_last   <= r_gnt_idx;
                    r_grant  <= '0;
                    r_state  <= SCH_IDLE;
                end
                SCH_FAULT: begin
                    if (clear_fault) begin
                        r_state <= SCH_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= SCH_IDLE;
                end
            endcase
        end
    end

    assign start        = (r_state == SCH_START);
    assign grant        = r_grant;
    assign done         = (r_state == SCH_DONE) ? r_grant : '0;
    assign pending      = r_pending;
    assign busy         = (r_state != SCH_IDLE);
    assign fault        = (r_state == SCH_FAULT);
    assign served_count = r_served;
    assign sched_state  = r_state;

endmodule
`default_nettype wire
